// File: rtl/mda_vram_sequencer_pkg.sv
// Shared character-cell phase constants and CPU slot FSM encoding for the MDA
// display path (the sequencer and the pixel pipeline decode the same phases).
package mda_vram_sequencer_pkg;

  localparam int SEQ_LEN = 18;

  localparam logic [4:0] SEQ_CHAR_ADDR = 5'd0;
  localparam logic [4:0] SEQ_CHAR_RD   = 5'd1;
  localparam logic [4:0] SEQ_ATT_ADDR  = 5'd2;
  localparam logic [4:0] SEQ_ATT_RD    = 5'd3;
  localparam logic [4:0] SEQ_CPU_A     = 5'd4;
  localparam logic [4:0] SEQ_CPU_B     = 5'd10;
  localparam logic [4:0] SEQ_LAST      = 5'd17;

  typedef enum logic [1:0] {
    CPU_IDLE = 2'd0,
    CPU_ADDR = 2'd1,
    CPU_XFER = 2'd2,
    CPU_DONE = 2'd3
  } cpu_state_e;

  function automatic logic [4:0] seq_next(input logic [4:0] seq);
    if (seq == 5'(SEQ_LEN - 1)) begin
      return 5'd0;
    end else begin
      return seq + 5'd1;
    end
  endfunction

endpackage

// File: rtl/mda_vram_sequencer_cpu_slot.sv
// CPU access engine for the shared VRAM: waits for a slot start, then runs a
// fixed address / transfer / acknowledge sequence inside that 4-clock slot.
module mda_vram_sequencer_cpu_slot
  import mda_vram_sequencer_pkg::*;
#(
  parameter int VRAM_AW = 19
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               slot_start,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [VRAM_AW-1:0] cpu_addr,
  input  logic [7:0]         cpu_wdata,
  input  logic [7:0]         vram_data,
  output logic               cpu_ack,
  output logic [7:0]         cpu_rdata,
  output logic               vram_we,
  output logic [7:0]         vram_dout,
  output logic               addr_phase,
  output logic [VRAM_AW-1:0] xfer_addr
);

  cpu_state_e         state_r, state_s;
  logic               we_lat_r;
  logic [VRAM_AW-1:0] addr_lat_r;
  logic [7:0]         wdata_lat_r;
  logic               ack_r;
  logic               vram_we_r;
  logic [7:0]         rdata_r;

  // Next-state decode; a request is only accepted on a slot boundary
  always_comb begin
    state_s = state_r;
    case (state_r)
      CPU_IDLE: begin
        if (slot_start && cpu_req) begin
          state_s = CPU_ADDR;
        end else begin
          state_s = CPU_IDLE;
        end
      end
      CPU_ADDR: state_s = CPU_XFER;
      CPU_XFER: state_s = CPU_DONE;
      CPU_DONE: state_s = CPU_IDLE;
      default:  state_s = CPU_IDLE;
    endcase
  end

  // State, request latches and strobes registered against the next state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= CPU_IDLE;
      we_lat_r    <= 1'b0;
      addr_lat_r  <= {VRAM_AW{1'b0}};
      wdata_lat_r <= 8'h00;
      ack_r       <= 1'b0;
      vram_we_r   <= 1'b0;
      rdata_r     <= 8'h00;
    end else begin
      state_r   <= state_s;
      ack_r     <= (state_s == CPU_DONE);
      vram_we_r <= (state_s == CPU_XFER) && we_lat_r;
      if ((state_r == CPU_IDLE) && (state_s == CPU_ADDR)) begin
        we_lat_r    <= cpu_we;
        addr_lat_r  <= cpu_addr;
        wdata_lat_r <= cpu_wdata;
      end
      // SRAM data lags the address by one clock, so it is valid during XFER
      if ((state_r == CPU_XFER) && !we_lat_r) begin
        rdata_r <= vram_data;
      end
    end
  end

  assign cpu_ack    = ack_r;
  assign cpu_rdata  = rdata_r;
  assign vram_we    = vram_we_r;
  assign vram_dout  = wdata_lat_r;
  assign addr_phase = (state_r == CPU_ADDR);
  assign xfer_addr  = addr_lat_r;

endmodule

// File: rtl/mda_vram_sequencer.sv
// MDA character-cell timing master: 18-clock phase counter, fetch strobes and
// the VRAM address mux shared between fixed display fetches and CPU slots.
module mda_vram_sequencer
  import mda_vram_sequencer_pkg::*;
#(
  parameter int VRAM_AW = 19
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [VRAM_AW-2:0] disp_addr,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [VRAM_AW-1:0] cpu_addr,
  input  logic [7:0]         cpu_wdata,
  output logic               cpu_ack,
  output logic [7:0]         cpu_rdata,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic               vram_we,
  output logic [7:0]         vram_dout,
  input  logic [7:0]         vram_data,
  output logic [4:0]         clk_seq,
  output logic               vram_read_char,
  output logic               vram_read_att,
  output logic               charrom_read,
  output logic               disp_pipeline,
  output logic               cell_tick
);

  logic [4:0]         clk_seq_r;
  logic [4:0]         seq_next_s;
  logic               read_char_r;
  logic               read_att_r;
  logic               cell_end_r;
  logic               slot_start_s;
  logic               addr_phase_s;
  logic [VRAM_AW-1:0] xfer_addr_s;
  logic [VRAM_AW-1:0] vram_addr_s;
  logic [VRAM_AW-1:0] vram_addr_hold_r;

  assign seq_next_s   = seq_next(clk_seq_r);
  assign slot_start_s = (clk_seq_r == SEQ_CPU_A) || (clk_seq_r == SEQ_CPU_B);

  // Phase counter; strobes decode the upcoming phase so they coincide with it
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_seq_r   <= 5'd0;
      read_char_r <= 1'b0;
      read_att_r  <= 1'b0;
      cell_end_r  <= 1'b0;
    end else begin
      clk_seq_r   <= seq_next_s;
      read_char_r <= (seq_next_s == SEQ_CHAR_RD);
      read_att_r  <= (seq_next_s == SEQ_ATT_RD);
      cell_end_r  <= (seq_next_s == SEQ_LAST);
    end
  end

  // Display addresses use disp_addr live: the CRTC only settles it at phase 0
  always_comb begin
    vram_addr_s = vram_addr_hold_r;
    if (!reset_n) begin
      vram_addr_s = {VRAM_AW{1'b0}};
    end else if (clk_seq_r == SEQ_CHAR_ADDR) begin
      vram_addr_s = {disp_addr, 1'b0};
    end else if (clk_seq_r == SEQ_ATT_ADDR) begin
      vram_addr_s = {disp_addr, 1'b1};
    end else if (addr_phase_s) begin
      vram_addr_s = xfer_addr_s;
    end else begin
      vram_addr_s = vram_addr_hold_r;
    end
  end

  // Last driven address, held through idle phases
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vram_addr_hold_r <= {VRAM_AW{1'b0}};
    end else begin
      vram_addr_hold_r <= vram_addr_s;
    end
  end

  mda_vram_sequencer_cpu_slot #(
    .VRAM_AW (VRAM_AW)
  ) u_cpu_slot (
    .clk        (clk),
    .reset_n    (reset_n),
    .slot_start (slot_start_s),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .vram_data  (vram_data),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .vram_we    (vram_we),
    .vram_dout  (vram_dout),
    .addr_phase (addr_phase_s),
    .xfer_addr  (xfer_addr_s)
  );

  assign vram_addr      = vram_addr_s;
  assign clk_seq        = clk_seq_r;
  assign vram_read_char = read_char_r;
  assign vram_read_att  = read_att_r;
  assign charrom_read   = cell_end_r;
  assign disp_pipeline  = cell_end_r;
  assign cell_tick      = cell_end_r;

endmodule

// File: tb/tb_mda_vram_sequencer.sv
// Self-checking bench for mda_vram_sequencer: cycle-time model of the cell
// schedule and CPU slots, a behavioural SRAM, and directed scenarios.
module tb_mda_vram_sequencer;

  localparam int AW = 19;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-2:0] disp_addr;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_ack;
  logic [7:0]    cpu_rdata;
  logic [AW-1:0] vram_addr;
  logic          vram_we;
  logic [7:0]    vram_dout;
  logic [7:0]    vram_data;
  logic [4:0]    clk_seq;
  logic          vram_read_char;
  logic          vram_read_att;
  logic          charrom_read;
  logic          disp_pipeline;
  logic          cell_tick;

  mda_vram_sequencer #(.VRAM_AW(AW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .disp_addr      (disp_addr),
    .cpu_req        (cpu_req),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_ack        (cpu_ack),
    .cpu_rdata      (cpu_rdata),
    .vram_addr      (vram_addr),
    .vram_we        (vram_we),
    .vram_dout      (vram_dout),
    .vram_data      (vram_data),
    .clk_seq        (clk_seq),
    .vram_read_char (vram_read_char),
    .vram_read_att  (vram_read_att),
    .charrom_read   (charrom_read),
    .disp_pipeline  (disp_pipeline),
    .cell_tick      (cell_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural SRAM with a one-clock registered read
  logic [7:0] sram    [0:1023];
  logic [7:0] ref_mem [0:1023];
  always @(posedge clk) begin
    vram_data <= sram[vram_addr[9:0]];
    if (vram_we) sram[vram_addr[9:0]] <= vram_dout;
  end

  // Model: phase = clocks since reset mod 18; a grant at a slot start puts
  // the address out 1 clock later, the write 2 later, the ack 3 later.
  int            m_seq = 0;
  int            m_k = 0;
  bit            m_busy = 1'b0;
  bit            m_valid = 1'b0;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_caddr = '0;
  logic [AW-1:0] m_hold = '0;
  logic [7:0]    m_wd = 8'h00;
  logic [7:0]    m_rdata = 8'h00;

  function automatic logic [AW-1:0] exp_addr();
    if (!reset_n) return '0;
    if (m_seq == 0) return {disp_addr, 1'b0};
    if (m_seq == 2) return {disp_addr, 1'b1};
    if (m_busy && m_k == 1) return m_caddr;
    return m_hold;
  endfunction

  initial forever begin
    @(posedge clk);
    if (!reset_n) begin
      m_seq = 0; m_k = 0; m_busy = 1'b0; m_rdata = 8'h00; m_hold = '0; m_valid = 1'b1;
    end else if (m_valid) begin
      m_hold = exp_addr();
      if (m_busy) begin
        if (m_k == 2) begin
          if (m_we) ref_mem[m_caddr[9:0]] = m_wd;
          else m_rdata = ref_mem[m_caddr[9:0]];
        end
        if (m_k == 3) m_busy = 1'b0;
        else m_k = m_k + 1;
      end else if (cpu_req && (m_seq == 4 || m_seq == 10)) begin
        m_busy = 1'b1; m_k = 1; m_we = cpu_we; m_caddr = cpu_addr; m_wd = cpu_wdata;
      end
      m_seq = (m_seq + 1) % 18;
    end
  end

  // Every-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("clk_seq", 32'(clk_seq), 32'(m_seq));
      chk("vram_read_char", 32'(vram_read_char), 32'(m_seq == 1));
      chk("vram_read_att", 32'(vram_read_att), 32'(m_seq == 3));
      chk("charrom_read", 32'(charrom_read), 32'(m_seq == 17));
      chk("disp_pipeline", 32'(disp_pipeline), 32'(m_seq == 17));
      chk("cell_tick", 32'(cell_tick), 32'(m_seq == 17));
      chk("vram_we", 32'(vram_we), 32'(m_busy && m_k == 2 && m_we));
      chk("cpu_ack", 32'(cpu_ack), 32'(m_busy && m_k == 3));
      chk("vram_addr", 32'(vram_addr), 32'(exp_addr()));
      chk("cpu_rdata", 32'(cpu_rdata), 32'(m_rdata));
      if (m_busy && m_k == 2 && m_we) chk("vram_dout", 32'(vram_dout), 32'(m_wd));
    end
  end

  // Advance to the cycle whose phase is s; inputs change 1 unit after the edge
  task automatic go_seq(input int s);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (int'(clk_seq) != s && n < 40);
    if (int'(clk_seq) != s) chk("go_seq_timeout", 32'(clk_seq), 32'(s));
  endtask

  initial begin : watchdog
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : main
    int n_char, n_att, n_tick, n, prev_seq, mism, acks;
    logic [7:0] orig;
    reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = 8'h00;
    disp_addr = 18'h00123;
    for (int i = 0; i < 1024; i++) begin
      sram[i] = 8'(i * 7 + 3);
      ref_mem[i] = sram[i];
    end
    sram[10'h246] = 8'h41; ref_mem[10'h246] = 8'h41;
    sram[10'h247] = 8'h07; ref_mem[10'h247] = 8'h07;
    sram[10'h333] = 8'h5A; ref_mem[10'h333] = 8'h5A;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_clk_seq", 32'(clk_seq), 32'd0);
    chk("rst_vram_addr", 32'(vram_addr), 32'd0);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_vram_we", 32'(vram_we), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_cell_tick", 32'(cell_tick), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // 100 cells of strobes from release
    n_char = 0; n_att = 0; n_tick = 0;
    for (int i = 0; i < 1800; i++) begin
      @(negedge clk);
      if (i == 0) chk("release_seq0", 32'(clk_seq), 32'd0);
      if (vram_read_char) begin n_char++; chk("char_phase", 32'(clk_seq), 32'd1); end
      if (vram_read_att) begin n_att++; chk("att_phase", 32'(clk_seq), 32'd3); end
      if (cell_tick) begin n_tick++; chk("tick_phase", 32'(clk_seq), 32'd17); end
    end
    chk("char_count", 32'(n_char), 32'd100);
    chk("att_count", 32'(n_att), 32'd100);
    chk("tick_count", 32'(n_tick), 32'd100);

    // Display fetch of cell 0x123
    go_seq(0); @(negedge clk); chk("disp_char_addr", 32'(vram_addr), 32'h246);
    go_seq(1); @(negedge clk); chk("disp_char_data", 32'(vram_data), 32'h41);
    chk("disp_char_strobe", 32'(vram_read_char), 32'd1);
    go_seq(2); @(negedge clk); chk("disp_att_addr", 32'(vram_addr), 32'h247);
    go_seq(3); @(negedge clk); chk("disp_att_data", 32'(vram_data), 32'h07);
    chk("disp_att_strobe", 32'(vram_read_att), 32'd1);

    // Write raised at seq 2, served in slot A
    go_seq(2);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h000F0; cpu_wdata = 8'hA5;
    go_seq(5); @(negedge clk); chk("wr_addr_seq5", 32'(vram_addr), 32'hF0);
    chk("wr_we_seq5", 32'(vram_we), 32'd0);
    go_seq(6); @(negedge clk); chk("wr_we_seq6", 32'(vram_we), 32'd1);
    chk("wr_dout_seq6", 32'(vram_dout), 32'hA5);
    go_seq(7); @(negedge clk); chk("wr_ack_seq7", 32'(cpu_ack), 32'd1);
    chk("wr_we_seq7", 32'(vram_we), 32'd0);
    cpu_req = 1'b0;
    go_seq(8); @(negedge clk); chk("wr_ack_seq8", 32'(cpu_ack), 32'd0);
    chk("wr_sram", 32'(sram[10'h0F0]), 32'hA5);

    // Read raised at seq 5 misses slot A, served in slot B
    go_seq(5);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00333;
    go_seq(7); @(negedge clk); chk("rd_no_ack_seq7", 32'(cpu_ack), 32'd0);
    go_seq(13); @(negedge clk); chk("rd_ack_seq13", 32'(cpu_ack), 32'd1);
    chk("rd_data", 32'(cpu_rdata), 32'h5A);
    cpu_req = 1'b0;
    go_seq(0); @(negedge clk); chk("after_rd_char_addr", 32'(vram_addr), 32'h246);
    go_seq(1); @(negedge clk); chk("after_rd_char_data", 32'(vram_data), 32'h41);
    go_seq(3); @(negedge clk); chk("after_rd_att_data", 32'(vram_data), 32'h07);
    chk("rd_data_held", 32'(cpu_rdata), 32'h5A);

    // 20 back-to-back writes, each raised the clock after the previous ack
    prev_seq = -1;
    for (int i = 0; i < 20; i++) begin
      cpu_req = 1'b1; cpu_we = 1'b1;
      cpu_addr = 19'(32'h100 + i); cpu_wdata = 8'(8'hC0 + i * 3);
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!cpu_ack && n < 40);
      if (!cpu_ack) chk("b2b_timeout", 32'd0, 32'd1);
      chk("b2b_ack_slot", 32'(clk_seq == 5'd7 || clk_seq == 5'd13), 32'd1);
      if (i > 0) chk("b2b_alternate", 32'(int'(clk_seq) != prev_seq), 32'd1);
      prev_seq = int'(clk_seq);
      cpu_req = 1'b0;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 20; i++)
      chk("b2b_mem", 32'(sram[10'h100 + i]), 32'(8'(8'hC0 + i * 3)));
    mism = 0;
    for (int i = 0; i < 1024; i++) if (sram[i] !== ref_mem[i]) mism++;
    chk("sram_vs_model", 32'(mism), 32'd0);

    // Reset asserted across the write phase of an accepted write
    orig = sram[10'h3F0];
    go_seq(2);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h003F0; cpu_wdata = 8'h99;
    go_seq(5);
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid_we", 32'(vram_we), 32'd0);
      chk("rst_mid_ack", 32'(cpu_ack), 32'd0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1; cpu_req = 1'b0;
    @(negedge clk); chk("rst_mid_release_seq", 32'(clk_seq), 32'd0);
    acks = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cpu_ack) acks++;
    end
    chk("rst_mid_no_ack", 32'(acks), 32'd0);
    chk("rst_mid_no_write", 32'(sram[10'h3F0]), 32'(orig));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
